// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared defaults, tag width derivation, FSM states and FIR error codes
// for the FIR channel scheduler.
package fir_sched_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int TAG_DEPTH_DEF = 16;

    localparam logic [1:0] FIR_ERR_OK = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tag_fifo.sv
// fir_tag_fifo: synchronous FIFO of channel tags for samples outstanding inside the FIR.
// Pushes when full and pops when empty are ignored.
module fir_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: shares one FIR core across NUM_CH channels, issuing held samples
// round-robin with a channel tag and re-attaching the tag to each returned result.
module fir_channel_scheduler import fir_sched_pkg::*; #(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 32,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF,
    localparam int CH_W     = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_overrun,
    output logic                     fir_sink_valid,
    output logic [DATA_W-1:0]        fir_sink_data,
    output logic [CH_W-1:0]          fir_sink_channel,
    output logic [1:0]               fir_sink_error,
    input  logic                     fir_source_valid,
    input  logic [OUT_W-1:0]         fir_source_data,
    input  logic [1:0]               fir_source_error,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_channel,
    output logic [OUT_W-1:0]         out_data,
    output logic                     busy,
    output logic                     tag_err
);

    state_e                    state_q, state_d;
    logic [NUM_CH-1:0]         pend_q, pend_d, ovr_q, gnt_oh;
    logic [DATA_W-1:0]         hold_q [NUM_CH];
    logic [CH_W-1:0]           last_q, gnt_ch, idx, tag;
    logic                      gnt_found, issue, pop, full, empty;
    logic [$clog2(TAG_DEPTH):0] count;
    logic                      sink_valid_q, out_valid_q, tag_err_q;
    logic [DATA_W-1:0]         sink_data_q;
    logic [CH_W-1:0]           sink_ch_q, out_ch_q;
    logic [OUT_W-1:0]          out_data_q;

    always_comb begin
        state_d = (state_q == ST_IDLE) ? (en ? ST_RUN : ST_IDLE) :
                  (state_q == ST_RUN)  ? (en ? ST_RUN : ST_DRAIN) :
                  (en ? ST_RUN : (count == '0) ? ST_IDLE : ST_DRAIN);
    end

    // Search begins one past the last granted channel so every channel gets a fair turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx       = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            idx = last_q + CH_W'(j + 1);
            if (!gnt_found && pend_q[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx;
            end
        end
    end

    // Issuing only while en is still high keeps fir_sink_valid out of DRAIN.
    assign issue  = (state_q == ST_RUN) && en && gnt_found && !full;
    assign gnt_oh = issue ? (NUM_CH'(1) << gnt_ch) : '0;
    assign pend_d = ch_valid | (pend_q & ~gnt_oh);
    assign pop    = fir_source_valid && !empty;

    fir_tag_fifo #(.W(CH_W), .DEPTH(TAG_DEPTH)) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .pop_i   (pop),
        .data_i  (gnt_ch),
        .data_o  (tag),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            ovr_q        <= '0;
            last_q       <= CH_W'(NUM_CH - 1);
            sink_valid_q <= 1'b0;
            sink_data_q  <= '0;
            sink_ch_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            tag_err_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_q | (ch_valid & pend_q & ~gnt_oh);
            if (issue) last_q <= gnt_ch;
            sink_valid_q <= issue;
            sink_data_q  <= issue ? hold_q[gnt_ch] : '0;
            sink_ch_q    <= issue ? gnt_ch : '0;
            out_valid_q  <= pop;
            out_ch_q     <= pop ? tag : '0;
            out_data_q   <= pop ? fir_source_data : '0;
            tag_err_q    <= tag_err_q | (fir_source_valid && (empty || fir_source_error != FIR_ERR_OK));
            for (int i = 0; i < NUM_CH; i++)
                if (ch_valid[i]) hold_q[i] <= ch_data[i*DATA_W +: DATA_W];
        end
    end

    assign ch_overrun       = ovr_q;
    assign fir_sink_valid   = sink_valid_q;
    assign fir_sink_data    = sink_data_q;
    assign fir_sink_channel = sink_ch_q;
    assign fir_sink_error   = FIR_ERR_OK;
    assign out_valid        = out_valid_q;
    assign out_channel      = out_ch_q;
    assign out_data         = out_data_q;
    assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign tag_err          = tag_err_q;

endmodule

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Time-multiplexes one band-pass FIR core across all beamformer microphone channels. Captures per-channel samples, issues them to the FIR's streaming sink in round-robin order with a channel tag, tracks outstanding tags, and re-attaches the channel number to each filtered result. Sits between the ADC capture front end and the delay-and-sum stage.

## Interface

- NUM_CH, 4, number of microphone channels (power of two, 2..16)
- DATA_W, 16, input sample width
- OUT_W, 32, filtered result width, truncated from the FIR output upstream
- TAG_DEPTH, 16, maximum outstanding samples inside the FIR (power of two)

Ports, clock and reset first:

- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-low reset
- en  in  1  run enable; level-sensitive
- ch_valid  in  NUM_CH  per-channel one-cycle sample strobe
- ch_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- ch_overrun  out  NUM_CH  sticky per-channel overrun flag
- fir_sink_valid  out  1  sample valid to FIR
- fir_sink_data  out  DATA_W  sample to FIR
- fir_sink_channel  out  CH_W  channel tag to FIR, CH_W = $clog2(NUM_CH)
- fir_sink_error  out  2  tied 2'b00
- fir_source_valid  in  1  FIR result valid
- fir_source_data  in  OUT_W  FIR result
- fir_source_error  in  2  FIR error code
- out_valid  out  1  tagged result valid
- out_channel  out  CH_W  channel of result
- out_data  out  OUT_W  result
- busy  out  1  high in RUN or DRAIN
- tag_err  out  1  sticky: result with empty tag FIFO, or nonzero fir_source_error

## Operation

- Per channel: holding register plus pending bit. ch_valid[i] loads register, sets pending[i] (in all states).
- ch_valid[i] while pending[i] set and channel i not issued that cycle: register overwritten (newest wins), ch_overrun[i] set. ch_valid[i] in the same cycle channel i is issued: pending stays set with new data, no overrun.
- FSM states IDLE, RUN, DRAIN.
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when tag FIFO empty. DRAIN -> RUN if en=1 again.
- Issue (RUN only): at most one per cycle. Requires any pending and tag FIFO count < TAG_DEPTH (count before this cycle's pop).
  - Round-robin grant: search starts at the channel after the last granted.
  - Issue drives fir_sink_valid=1, fir_sink_data, fir_sink_channel for one cycle, pushes the channel into the tag FIFO, and clears pending.
- Result: fir_source_valid pops the tag FIFO. Next cycle: out_valid=1, out_channel=popped tag, out_data=fir_source_data.
  - FIFO empty on fir_source_valid: no out_valid, tag_err set.
  - Nonzero fir_source_error: result still forwarded, tag_err set.
- Simultaneous push and pop allowed; count unchanged.
- Sticky flags clear only on reset.

## Timing

- Reset values: all outputs 0; FSM IDLE; tag FIFO empty; round-robin pointer selects channel 0 first; all pending clear.
- Reset mid-operation discards pending samples and outstanding tags immediately. FIR results arriving after reset release with an empty FIFO set tag_err.
- Edge k samples ch_valid in RUN with FIFO room: fir_sink_valid high in the cycle after edge k+1 (2-cycle latency).
- Edge m samples fir_source_valid: out_valid high in the cycle after edge m (1-cycle latency).
- Back-to-back issues permitted: sustained throughput one sample per clock across all channels.
- fir_sink_valid never high in IDLE or DRAIN.

## Structure

- Package fir_sched_pkg: NUM_CH/TAG_DEPTH defaults, CH_W derivation, FSM state enum, FIR error code constants (2'b00 OK).
- Sub-module fir_tag_fifo: synchronous FIFO of CH_W-bit tags with push, pop, count, full, and empty. Same clk/rst convention.
- Round-robin arbiter and holding registers stay inline.

## Test plan

- en=1; ch_valid=4'b1111 once, data 0x0001..0x0004 -> fir_sink_channel 0,1,2,3 on consecutive cycles starting 2 cycles later; no overrun.
- ch_valid[2] pulsed twice while en=0 (0x0AAA, then 0x0BBB), then en=1 -> single issue of 0x0BBB on channel 2; ch_overrun=4'b0100.
- FIR model with latency 7 returns data+0x100 -> out_channel/out_data match issue order; tag_err stays 0.
- Hold fir_source_valid low; 16 issues fill the FIFO -> 17th pending sample withheld until one result pops, then issues the next cycle.
- en dropped with 3 outstanding -> busy stays 1 until the third result returns, then IDLE with busy=0; no fir_sink_valid meanwhile.
- fir_source_valid with empty FIFO, or fir_source_error=2'b01 -> tag_err=1 held. Reset pulse mid-stream -> all outputs 0, FIFO empty.
